// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares the single-port video RAM between the display
// scanout reader (strict priority) and buffered CPU pixel writes. CPU writes
// are range-checked, linearised to a RAM address and queued in a small FIFO
// that drains on any cycle without a scanout request.
module vram_port_arbiter #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 384,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iCpuWrEn,
    input  logic [15:0]       iCpuCol,
    input  logic [15:0]       iCpuRow,
    input  logic [2:0]        iCpuColor,
    output logic              oCpuStall,
    input  logic              iScanRdReq,
    input  logic [ADDR_W-1:0] iScanAddr,
    output logic              oScanRdValid,
    output logic [2:0]        oScanRdData,
    output logic [ADDR_W-1:0] oRamAddr,
    output logic              oRamWrEn,
    output logic [2:0]        oRamWrData,
    input  logic [2:0]        iRamRdData,
    output logic              oOverflow,
    output logic              oDropped,
    output logic [3:0]        oFifoLevel
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fifo_addr_q  [FIFO_DEPTH];
    logic [2:0]        fifo_color_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]        level_q, level_d;
    logic              stall_q, stall_d;
    logic              ovf_q, ovf_d;
    logic              dropped_q, dropped_d;
    logic              scan_vld_q, scan_vld_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wren_q, ram_wren_d;
    logic [2:0]        ram_wdata_q, ram_wdata_d;

    logic              in_range_s;
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] lin_addr_s;

    // Classify the incoming CPU write and decide whether the FIFO moves this cycle.
    always_comb begin
        in_range_s = (32'(iCpuCol) < 32'(H_RES)) && (32'(iCpuRow) < 32'(V_RES));
        lin_addr_s = ADDR_W'(32'(iCpuRow) * 32'(H_RES) + 32'(iCpuCol));
        // Stall is the registered full flag, so a push in a full cycle is lost
        // even if a pop frees a slot in that same cycle.
        push_s     = iCpuWrEn && in_range_s && !stall_q;
        pop_s      = !iScanRdReq && (level_q != 4'd0);
    end

    // Grant arbitration: scanout first, then the FIFO head, otherwise idle.
    always_comb begin
        state_d     = ST_IDLE;
        ram_addr_d  = ram_addr_q;
        ram_wren_d  = 1'b0;
        ram_wdata_d = ram_wdata_q;
        if (iScanRdReq) begin
            state_d    = ST_SCAN;
            ram_addr_d = iScanAddr;
        end else if (level_q != 4'd0) begin
            state_d     = ST_WRITE;
            ram_addr_d  = fifo_addr_q[rd_ptr_q];
            ram_wdata_d = fifo_color_q[rd_ptr_q];
            ram_wren_d  = 1'b1;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // FIFO pointers, occupancy and status flags for the next cycle.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1'b1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1'b1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase
        stall_d    = (level_d == 4'(FIFO_DEPTH));
        ovf_d      = ovf_q | (iCpuWrEn && in_range_s && stall_q);
        dropped_d  = iCpuWrEn && !in_range_s;
        // The RAM returns data one cycle after a scan address was presented.
        scan_vld_d = (state_q == ST_SCAN);
    end

    // Control state, status flags and the registered RAM interface.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= 4'd0;
            stall_q     <= 1'b0;
            ovf_q       <= 1'b0;
            dropped_q   <= 1'b0;
            scan_vld_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wren_q  <= 1'b0;
            ram_wdata_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            stall_q     <= stall_d;
            ovf_q       <= ovf_d;
            dropped_q   <= dropped_d;
            scan_vld_q  <= scan_vld_d;
            ram_addr_q  <= ram_addr_d;
            ram_wren_q  <= ram_wren_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // FIFO storage: accepted writes land at the write pointer.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i]  <= '0;
                fifo_color_q[i] <= 3'd0;
            end
        end else if (push_s) begin
            fifo_addr_q[wr_ptr_q]  <= lin_addr_s;
            fifo_color_q[wr_ptr_q] <= iCpuColor;
        end else begin
            fifo_addr_q[wr_ptr_q]  <= fifo_addr_q[wr_ptr_q];
            fifo_color_q[wr_ptr_q] <= fifo_color_q[wr_ptr_q];
        end
    end

    assign oCpuStall    = stall_q;
    assign oScanRdValid = scan_vld_q;
    assign oScanRdData  = scan_vld_q ? iRamRdData : 3'd0;
    assign oRamAddr     = ram_addr_q;
    assign oRamWrEn     = ram_wren_q;
    assign oRamWrData   = ram_wdata_q;
    assign oOverflow    = ovf_q;
    assign oDropped     = dropped_q;
    assign oFifoLevel   = level_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Testbench for vram_port_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based transaction model.
module tb_vram_port_arbiter;

    localparam int H  = 320;
    localparam int V  = 384;
    localparam int AW = 17;
    localparam int NW = 1 << AW;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          iCpuWrEn;
    logic [15:0]   iCpuCol, iCpuRow;
    logic [2:0]    iCpuColor;
    logic          oCpuStall;
    logic          iScanRdReq;
    logic [AW-1:0] iScanAddr;
    logic          oScanRdValid;
    logic [2:0]    oScanRdData;
    logic [AW-1:0] oRamAddr;
    logic          oRamWrEn;
    logic [2:0]    oRamWrData;
    logic [2:0]    iRamRdData;
    logic          oOverflow, oDropped;
    logic [3:0]    oFifoLevel;
    logic          preload;

    int total = 0;
    int bad   = 0;

    vram_port_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .iCpuWrEn(iCpuWrEn), .iCpuCol(iCpuCol), .iCpuRow(iCpuRow), .iCpuColor(iCpuColor),
        .oCpuStall(oCpuStall),
        .iScanRdReq(iScanRdReq), .iScanAddr(iScanAddr),
        .oScanRdValid(oScanRdValid), .oScanRdData(oScanRdData),
        .oRamAddr(oRamAddr), .oRamWrEn(oRamWrEn), .oRamWrData(oRamWrData),
        .iRamRdData(iRamRdData),
        .oOverflow(oOverflow), .oDropped(oDropped), .oFifoLevel(oFifoLevel)
    );

    always #5 Clock = ~Clock;

    function automatic logic [2:0] init_pix(int a);
        return 3'((a * 7) ^ (a >> 5));
    endfunction

    // Synchronous single-port video RAM: one-cycle read latency.
    logic [2:0] mem [NW];
    always @(posedge Clock) begin
        if (preload) begin
            for (int i = 0; i < NW; i++) mem[i] <= init_pix(i);
        end else begin
            if (oRamWrEn) mem[oRamAddr] <= oRamWrData;
            iRamRdData <= mem[oRamAddr];
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed { logic [AW-1:0] a; logic [2:0] c; } ent_t;
    ent_t        q[$];
    logic [2:0]  gold [NW];
    logic [AW-1:0] e_addr;
    logic        e_wren, e_vld, e_stall, e_ovf, e_drop;
    logic [2:0]  e_wdata, e_rd;
    int          e_lvl;
    logic        p_req;
    logic [2:0]  p_data;

    task automatic model_reset();
        q.delete();
        e_addr = '0; e_wren = 1'b0; e_wdata = 3'd0; e_vld = 1'b0; e_rd = 3'd0;
        e_stall = 1'b0; e_ovf = 1'b0; e_drop = 1'b0; e_lvl = 0;
        p_req = 1'b0; p_data = 3'd0;
    endtask

    task automatic model_edge();
        bit   full;
        ent_t e;
        full  = (q.size() == 8);
        e_vld = p_req;
        e_rd  = p_req ? p_data : 3'd0;
        p_req = iScanRdReq;
        if (iScanRdReq) p_data = gold[iScanAddr];
        e_drop = 1'b0;
        if (iScanRdReq) begin
            e_addr = iScanAddr;
            e_wren = 1'b0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            e_addr = e.a; e_wdata = e.c; e_wren = 1'b1;
            gold[e.a] = e.c;
        end else begin
            e_wren = 1'b0;
        end
        if (iCpuWrEn) begin
            if (int'(iCpuCol) >= H || int'(iCpuRow) >= V) e_drop = 1'b1;
            else if (full) e_ovf = 1'b1;
            else begin
                e.a = AW'(int'(iCpuRow) * H + int'(iCpuCol));
                e.c = iCpuColor;
                q.push_back(e);
            end
        end
        e_lvl   = q.size();
        e_stall = (q.size() == 8);
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("ram_wren", 32'(oRamWrEn), 32'(e_wren));
        check("ram_addr", 32'(oRamAddr), 32'(e_addr));
        if (e_wren) check("ram_wdata", 32'(oRamWrData), 32'(e_wdata));
        check("scan_vld", 32'(oScanRdValid), 32'(e_vld));
        check("scan_data", 32'(oScanRdData), 32'(e_rd));
        check("stall", 32'(oCpuStall), 32'(e_stall));
        check("level", 32'(oFifoLevel), 32'(e_lvl));
        check("overflow", 32'(oOverflow), 32'(e_ovf));
        check("dropped", 32'(oDropped), 32'(e_drop));
    endtask

    task automatic cycle();
        @(posedge Clock);
        if (!Reset) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_in();
        iCpuWrEn = 1'b0; iScanRdReq = 1'b0;
    endtask

    task automatic push(int col, int row, int color, bit req);
        iCpuWrEn = 1'b1; iCpuCol = 16'(col); iCpuRow = 16'(row); iCpuColor = 3'(color);
        iScanRdReq = req; iScanAddr = AW'($urandom_range(NW - 1));
        cycle();
        iCpuWrEn = 1'b0;
    endtask

    task automatic idle_cycles(int n);
        idle_in();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic scan_cycles(int n);
        iCpuWrEn = 1'b0; iScanRdReq = 1'b1;
        for (int i = 0; i < n; i++) begin
            iScanAddr = AW'($urandom_range(NW - 1));
            cycle();
        end
        iScanRdReq = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NW; i++) gold[i] = init_pix(i);
        model_reset();
        Reset = 1'b0; preload = 1'b1; iCpuWrEn = 1'b0; iCpuCol = 16'd0; iCpuRow = 16'd0;
        iCpuColor = 3'd0; iScanRdReq = 1'b0; iScanAddr = '0;
        @(posedge Clock); #1;
        preload = 1'b0;
        compare_all();
        cycle();
        Reset = 1'b1;

        // Reset mid-read: request at cycle 5, reset at cycle 6
        idle_cycles(4);
        iScanRdReq = 1'b1; iScanAddr = AW'(1234);
        cycle();
        iScanRdReq = 1'b0; Reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        idle_cycles(2);
        Reset = 1'b1;
        idle_cycles(4);

        // Single write, no scanout
        push(10, 2, 7, 1'b0);
        idle_cycles(3);

        // Scan priority with three writes pushed during the scan burst
        scan_cycles(5);
        push(1, 1, 3, 1'b1);
        scan_cycles(3);
        push(2, 1, 4, 1'b1);
        push(3, 1, 5, 1'b1);
        scan_cycles(10);
        idle_cycles(5);

        // Full FIFO under sustained scanout
        for (int i = 0; i < 9; i++) push(100 + i, 50, i, 1'b1);
        scan_cycles(3);
        idle_cycles(10);

        // Out-of-range writes
        push(320, 0, 1, 1'b0);
        push(0, 384, 2, 1'b0);
        idle_cycles(3);

        // Boundary corner, then read it back through scanout
        push(319, 383, 6, 1'b0);
        idle_cycles(3);
        iScanRdReq = 1'b1; iScanAddr = AW'(122879);
        cycle();
        idle_cycles(3);

        // Random traffic in phases of varying scan pressure
        for (int ph = 0; ph < 30; ph++) begin
            int pct;
            pct = $urandom_range(100);
            for (int i = 0; i < 100; i++) begin
                int r;
                iScanRdReq = ($urandom_range(99) < pct);
                iScanAddr  = AW'($urandom_range(NW - 1));
                iCpuWrEn   = ($urandom_range(1) == 1);
                r = $urandom_range(19);
                iCpuCol   = (r == 0) ? 16'(320 + $urandom_range(500)) : (r == 1) ? 16'd319 : 16'($urandom_range(319));
                r = $urandom_range(19);
                iCpuRow   = (r == 0) ? 16'(384 + $urandom_range(500)) : (r == 1) ? 16'd383 : 16'($urandom_range(383));
                iCpuColor = 3'($urandom_range(7));
                cycle();
            end
        end
        idle_cycles(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
